input_debounce: RTL and testbench

Debounce and edge-event stage fed directly by the `data_sync` output of the two-flop synchronizer. It filters the synchronized push-button or strap input by requiring N consecutive agreeing samples before changing its output level. It emits single-cycle press/release pulses to the control logic. Optionally, it also emits a long-press pulse followed by auto-repeat pulses.

---
 rtl/input_debounce.sv | 161 ++++++++++++++++
 tb/tb_input_debounce.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/input_debounce.sv
// Debounce filter with registered press/release strobes and a saturating bounce counter.
// Optional long-press / auto-repeat strobe is enabled with `define INPUT_DEBOUNCE_HOLD_EN.
module input_debounce #(
  parameter logic INIT            = 1'b1,
  parameter int   DEBOUNCE_CYCLES = 16,
  parameter int   HOLD_CYCLES     = 50_000_000,
  parameter int   REPEAT_CYCLES   = 10_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       data_in,
  output logic       level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       hold_pulse,
  output logic [7:0] bounce_cnt
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_PEND,
    ACTIVE,
    RELEASE_PEND
  } state_t;

  if (DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_bad_params
    $error("input_debounce: illegal timing parameters");
  end

  state_t          state, state_n;
  logic [DB_W-1:0] db_cnt, db_cnt_n;
  logic            level_n;
  logic            press_n;
  logic            release_n;
  logic [7:0]      bounce_n;
  logic            differ;
  logic            commit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      db_cnt        <= '0;
      level         <= INIT;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      bounce_cnt    <= 8'd0;
    end else begin
      state         <= state_n;
      db_cnt        <= db_cnt_n;
      level         <= level_n;
      press_pulse   <= press_n;
      release_pulse <= release_n;
      bounce_cnt    <= bounce_n;
    end
  end

  // Stable states and pending states share one rule: a differing sample that
  // reaches the last count commits, so DEBOUNCE_CYCLES=1 commits straight from
  // a stable state because db_cnt is always zero there.
  always_comb begin
    state_n   = state;
    db_cnt_n  = db_cnt;
    level_n   = level;
    press_n   = 1'b0;
    release_n = 1'b0;
    bounce_n  = bounce_cnt;
    differ    = (data_in != level);
    commit    = 1'b0;

    case (state)
      IDLE, ACTIVE: begin
        if (!differ) begin
          db_cnt_n = '0;
        end else if (db_cnt == DB_LAST) begin
          commit = 1'b1;
        end else begin
          db_cnt_n = db_cnt + DB_W'(1);
          state_n  = (state == IDLE) ? PRESS_PEND : RELEASE_PEND;
        end
      end
      PRESS_PEND, RELEASE_PEND: begin
        if (!differ) begin
          db_cnt_n = '0;
          state_n  = (state == PRESS_PEND) ? IDLE : ACTIVE;
          if (bounce_cnt != 8'hFF) begin
            bounce_n = bounce_cnt + 8'd1;
          end
        end else if (db_cnt == DB_LAST) begin
          commit = 1'b1;
        end else begin
          db_cnt_n = db_cnt + DB_W'(1);
        end
      end
      default: begin
        state_n  = IDLE;
        db_cnt_n = '0;
        level_n  = INIT;
      end
    endcase

    if (commit) begin
      level_n  = data_in;
      db_cnt_n = '0;
      if (data_in == ~INIT) begin
        press_n = 1'b1;
        state_n = ACTIVE;
      end else begin
        release_n = 1'b1;
        state_n   = IDLE;
      end
    end
  end

`ifdef INPUT_DEBOUNCE_HOLD_EN
  localparam int HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HC_W     = $clog2(HOLD_MAX + 1);
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CYCLES - 1);
  localparam logic [HC_W-1:0] REP_LAST  = HC_W'(REPEAT_CYCLES - 1);

  logic [HC_W-1:0] hold_cnt, hold_cnt_n;
  logic            repeating, repeating_n;
  logic            hold_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt   <= '0;
      repeating  <= 1'b0;
      hold_pulse <= 1'b0;
    end else begin
      hold_cnt   <= hold_cnt_n;
      repeating  <= repeating_n;
      hold_pulse <= hold_n;
    end
  end

  // The counter only runs while ACTIVE persists; any entry into or exit from
  // ACTIVE restarts the long-press interval from zero.
  always_comb begin
    hold_cnt_n  = hold_cnt;
    repeating_n = repeating;
    hold_n      = 1'b0;
    if (state != ACTIVE || state_n != ACTIVE) begin
      hold_cnt_n  = '0;
      repeating_n = 1'b0;
    end else if ((!repeating && hold_cnt == HOLD_LAST) ||
                 (repeating && hold_cnt == REP_LAST)) begin
      hold_n      = 1'b1;
      hold_cnt_n  = '0;
      repeating_n = 1'b1;
    end else begin
      hold_cnt_n = hold_cnt + HC_W'(1);
    end
  end
`else
  assign hold_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_input_debounce.sv
// Directed self-checking bench for input_debounce (INIT=1, DEBOUNCE=4, HOLD=10, REPEAT=5).
// Hold expectations follow whether INPUT_DEBOUNCE_HOLD_EN is defined for the build.
module tb_input_debounce;

`ifdef INPUT_DEBOUNCE_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       data_in = 1'b1;
  logic       level;
  logic       press_pulse;
  logic       release_pulse;
  logic       hold_pulse;
  logic [7:0] bounce_cnt;

  int assertCount = 0;
  int failCount   = 0;
  int pressCount  = 0;

  input_debounce #(
    .INIT           (1'b1),
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (10),
    .REPEAT_CYCLES  (5)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in      (data_in),
    .level        (level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .hold_pulse   (hold_pulse),
    .bounce_cnt   (bounce_cnt)
  );

  always #5 clk = ~clk;

  // One comparison: counts it and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drive one sample and step to just after the edge that captures it.
  task automatic applyStimulus(input logic d);
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset held low, then released with the input idle
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_level", level, 1);
    checkOutput("rst_pulses", {press_pulse, release_pulse, hold_pulse}, 0);
    checkOutput("rst_bounce", bounce_cnt, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1);
      checkOutput("idle_outs", {level, press_pulse, release_pulse, hold_pulse}, 4'b1000);
    end
    checkOutput("idle_bounce", bounce_cnt, 0);

    // Clean press held 30 cycles past the press strobe
    for (int i = 0; i < 33; i++) begin
      applyStimulus(1'b0);
      checkOutput("press_level", level, (i >= 3) ? 0 : 1);
      checkOutput("press_pulse", press_pulse, (i == 3) ? 1 : 0);
      checkOutput("press_no_release", release_pulse, 0);
      checkOutput("hold_pulse", hold_pulse,
                  (HOLD_EN && i >= 13 && ((i - 13) % 5) == 0) ? 1 : 0);
    end

    // Clean release; the due repeat strobe must be suppressed
    for (int j = 0; j < 8; j++) begin
      applyStimulus(1'b1);
      checkOutput("release_level", level, (j >= 3) ? 1 : 0);
      checkOutput("release_pulse", release_pulse, (j == 3) ? 1 : 0);
      checkOutput("release_no_press", press_pulse, 0);
      checkOutput("release_no_hold", hold_pulse, 0);
    end
    checkOutput("clean_bounce", bounce_cnt, 0);

    // Bounce: 0,0,0,1 then 0 held
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0);
      checkOutput("bnc_pend", {level, press_pulse, release_pulse}, 3'b100);
    end
    applyStimulus(1'b1);
    checkOutput("bnc_glitch", {level, press_pulse, release_pulse}, 3'b100);
    checkOutput("bnc_count", bounce_cnt, 1);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0);
      checkOutput("bnc_press", press_pulse, (k == 3) ? 1 : 0);
      checkOutput("bnc_level", level, (k >= 3) ? 0 : 1);
    end
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1);
      checkOutput("bnc_release", release_pulse, (k == 3) ? 1 : 0);
    end
    checkOutput("bnc_final_level", level, 1);
    checkOutput("bnc_final_count", bounce_cnt, 1);

    // Reset two cycles into PRESS_PEND
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_outs", {level, press_pulse, release_pulse, hold_pulse}, 4'b1000);
    checkOutput("midrst_bounce", bounce_cnt, 0);
    data_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1);
      checkOutput("postrst_outs", {level, press_pulse, release_pulse, hold_pulse}, 4'b1000);
    end

    // Reset two cycles into RELEASE_PEND forces level back to idle at once
    for (int k = 0; k < 6; k++) applyStimulus(1'b0);
    checkOutput("act_level", level, 0);
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    checkOutput("relpend_level", level, 0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("actrst_level", level, 1);
    checkOutput("actrst_pulses", {press_pulse, release_pulse, hold_pulse}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1);
      checkOutput("actrst_after", {level, press_pulse, release_pulse}, 3'b100);
    end

    // 300 single-cycle glitches saturate the bounce counter
    for (int g = 1; g <= 300; g++) begin
      applyStimulus(1'b0);
      if (press_pulse) pressCount++;
      applyStimulus(1'b1);
      if (press_pulse) pressCount++;
      if (g == 254) checkOutput("sat_254", bounce_cnt, 254);
      if (g == 255) checkOutput("sat_255", bounce_cnt, 255);
    end
    checkOutput("sat_300", bounce_cnt, 255);
    checkOutput("sat_level", level, 1);
    checkOutput("sat_no_press", pressCount, 0);
    for (int g = 0; g < 5; g++) begin
      applyStimulus(1'b0);
      applyStimulus(1'b1);
    end
    checkOutput("sat_hold", bounce_cnt, 255);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
